// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: RAW scoreboard, saturation stall, branch flush FSM.
// Optional operand forwarding / load-use-only stalling enabled by defining HAZARD_FWD_EN.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       dec_valid_i,
  input  logic [3:0] dec_r1_addr_i,
  input  logic [3:0] dec_r2_addr_i,
  input  logic       dec_r1_used_i,
  input  logic       dec_r2_used_i,
  input  logic [3:0] dec_rd_addr_i,
  input  logic       dec_wr_en_i,
  input  logic       ex_valid_i,
  input  logic [3:0] ex_rd_addr_i,
  input  logic       ex_wr_en_i,
  input  logic       ex_is_load_i,
  input  logic       mem_valid_i,
  input  logic [3:0] mem_rd_addr_i,
  input  logic       mem_wr_en_i,
  input  logic       wb_en_i,
  input  logic [3:0] wb_addr_i,
  input  logic       sq_en_i,
  input  logic [3:0] sq_addr_i,
  input  logic       branch_taken_i,
  output logic       issue_o,
  output logic       stall_o,
  output logic       flush_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o
);

  localparam int               NREG       = 15;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       PC_ADDR    = 4'd15;
  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic [CNT_W-1:0] cnt_r1, cnt_r2, cnt_rd;
  logic             pend_a, pend_b, sat;
  logic             stall_raw;
  logic             stall_int, issue_int, flush_int;
  logic [1:0]       fwd_a_int, fwd_b_int;
  logic             underflow;

  // Scoreboard lookups; r15 has no entry and always reads as idle.
  always_comb begin
    cnt_r1 = '0;
    cnt_r2 = '0;
    cnt_rd = '0;
    for (int r = 0; r < NREG; r++) begin
      if (dec_r1_addr_i == 4'(r)) cnt_r1 = cnt_q[r];
      if (dec_r2_addr_i == 4'(r)) cnt_r2 = cnt_q[r];
      if (dec_rd_addr_i == 4'(r)) cnt_rd = cnt_q[r];
    end
  end

  always_comb begin
    pend_a = dec_r1_used_i & (dec_r1_addr_i != PC_ADDR) & (cnt_r1 != '0);
    pend_b = dec_r2_used_i & (dec_r2_addr_i != PC_ADDR) & (cnt_r2 != '0);
    sat    = dec_wr_en_i & (dec_rd_addr_i != PC_ADDR) & (cnt_rd == CNT_MAX);
  end

`ifdef HAZARD_FWD_EN
  logic load_use_a, load_use_b;
  logic unused_pend;

  always_comb begin
    load_use_a = dec_r1_used_i & ex_valid_i & ex_wr_en_i & ex_is_load_i &
                 (ex_rd_addr_i == dec_r1_addr_i);
    load_use_b = dec_r2_used_i & ex_valid_i & ex_wr_en_i & ex_is_load_i &
                 (ex_rd_addr_i == dec_r2_addr_i);
    stall_raw  = load_use_a | load_use_b | sat;
  end

  // Youngest producer wins: EX, then MEM, then the register-file write port.
  always_comb begin
    fwd_a_int = 2'd0;
    if (ex_valid_i & ex_wr_en_i & (ex_rd_addr_i == dec_r1_addr_i))
      fwd_a_int = 2'd1;
    else if (mem_valid_i & mem_wr_en_i & (mem_rd_addr_i == dec_r1_addr_i))
      fwd_a_int = 2'd2;
    else if (wb_en_i & (wb_addr_i == dec_r1_addr_i))
      fwd_a_int = 2'd3;

    fwd_b_int = 2'd0;
    if (ex_valid_i & ex_wr_en_i & (ex_rd_addr_i == dec_r2_addr_i))
      fwd_b_int = 2'd1;
    else if (mem_valid_i & mem_wr_en_i & (mem_rd_addr_i == dec_r2_addr_i))
      fwd_b_int = 2'd2;
    else if (wb_en_i & (wb_addr_i == dec_r2_addr_i))
      fwd_b_int = 2'd3;
  end

  assign unused_pend = pend_a ^ pend_b;
`else
  logic unused_fwd_inputs;

  always_comb begin
    stall_raw = pend_a | pend_b | sat;
    fwd_a_int = 2'd0;
    fwd_b_int = 2'd0;
  end

  assign unused_fwd_inputs = ^{ex_valid_i, ex_rd_addr_i, ex_wr_en_i, ex_is_load_i,
                               mem_valid_i, mem_rd_addr_i, mem_wr_en_i};
`endif

  // A flush overrides any stall; everything is held low while reset is asserted.
  always_comb begin
    flush_int = (state_q == ST_FLUSH);
    stall_int = stall_raw & ~flush_int & reset_ni;
    issue_int = dec_valid_i & ~stall_int & ~flush_int & reset_ni;
  end

  assign issue_o     = issue_int;
  assign stall_o     = stall_int;
  assign flush_o     = flush_int;
  assign fwd_a_sel_o = reset_ni ? fwd_a_int : 2'd0;
  assign fwd_b_sel_o = reset_ni ? fwd_b_int : 2'd0;

  // Net scoreboard update: issue increment, writeback and squash decrements in one step.
  always_comb begin
    underflow = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      logic             inc_m, wb_m, sq_m;
      logic [CNT_W+1:0] up, down;
      inc_m = issue_int & dec_wr_en_i & (dec_rd_addr_i == 4'(r));
      wb_m  = wb_en_i & (wb_addr_i == 4'(r));
      sq_m  = sq_en_i & (sq_addr_i == 4'(r));
      up    = (CNT_W+2)'(cnt_q[r]) + (CNT_W+2)'(inc_m);
      down  = (CNT_W+2)'(wb_m) + (CNT_W+2)'(sq_m);
      if (up < down) begin
        cnt_d[r]  = '0;
        underflow = 1'b1;
      end else begin
        cnt_d[r]  = CNT_W'(up - down);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (branch_taken_i) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (branch_taken_i) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q == 3'd1) begin
          state_d = ST_IDLE;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      fcnt_q  <= 3'd0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_ni) !underflow);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a per-register pending-write model.
// Define HAZARD_FWD_EN on both bench and RTL to exercise the forwarding build.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 2;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       dec_valid_i, dec_r1_used_i, dec_r2_used_i, dec_wr_en_i;
  logic [3:0] dec_r1_addr_i, dec_r2_addr_i, dec_rd_addr_i;
  logic       ex_valid_i, ex_wr_en_i, ex_is_load_i;
  logic [3:0] ex_rd_addr_i;
  logic       mem_valid_i, mem_wr_en_i;
  logic [3:0] mem_rd_addr_i;
  logic       wb_en_i, sq_en_i, branch_taken_i;
  logic [3:0] wb_addr_i, sq_addr_i;
  logic       issue_o, stall_o, flush_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .dec_valid_i(dec_valid_i), .dec_r1_addr_i(dec_r1_addr_i), .dec_r2_addr_i(dec_r2_addr_i),
    .dec_r1_used_i(dec_r1_used_i), .dec_r2_used_i(dec_r2_used_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_wr_en_i(dec_wr_en_i),
    .ex_valid_i(ex_valid_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_wr_en_i(ex_wr_en_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_valid_i(mem_valid_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_wr_en_i(mem_wr_en_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .sq_en_i(sq_en_i), .sq_addr_i(sq_addr_i),
    .branch_taken_i(branch_taken_i),
    .issue_o(issue_o), .stall_o(stall_o), .flush_o(flush_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int pend [16];
  int fl_left;
  logic       obs_issue, obs_stall, obs_flush;
  logic [1:0] obs_fa, obs_fb;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    dec_valid_i = 0; dec_r1_used_i = 0; dec_r2_used_i = 0; dec_wr_en_i = 0;
    dec_r1_addr_i = 0; dec_r2_addr_i = 0; dec_rd_addr_i = 0;
    ex_valid_i = 0; ex_wr_en_i = 0; ex_is_load_i = 0; ex_rd_addr_i = 0;
    mem_valid_i = 0; mem_wr_en_i = 0; mem_rd_addr_i = 0;
    wb_en_i = 0; wb_addr_i = 0; sq_en_i = 0; sq_addr_i = 0; branch_taken_i = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    fl_left = 0;
  endtask

  function automatic logic pending(input logic used, input logic [3:0] a);
    return used && (a != 4'd15) && (pend[a] != 0);
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic load_use(input logic used, input logic [3:0] a);
    return used && ex_valid_i && ex_wr_en_i && ex_is_load_i && (ex_rd_addr_i == a);
  endfunction

  function automatic logic [1:0] fwd_src(input logic [3:0] a);
    if (ex_valid_i && ex_wr_en_i && ex_rd_addr_i == a) return 2'd1;
    if (mem_valid_i && mem_wr_en_i && mem_rd_addr_i == a) return 2'd2;
    if (wb_en_i && wb_addr_i == a) return 2'd3;
    return 2'd0;
  endfunction
`endif

  // Called at posedge+1 with inputs driven; checks at the falling edge, advances the model.
  task automatic step();
    logic sat, stc, fl, st, is;
    logic [1:0] ea, eb;
    #4;
    sat = dec_wr_en_i && (dec_rd_addr_i != 4'd15) && (pend[dec_rd_addr_i] == CMAX);
`ifdef HAZARD_FWD_EN
    stc = sat || load_use(dec_r1_used_i, dec_r1_addr_i) || load_use(dec_r2_used_i, dec_r2_addr_i);
    ea  = fwd_src(dec_r1_addr_i);
    eb  = fwd_src(dec_r2_addr_i);
`else
    stc = sat || pending(dec_r1_used_i, dec_r1_addr_i) || pending(dec_r2_used_i, dec_r2_addr_i);
    ea  = 2'd0;
    eb  = 2'd0;
`endif
    fl = (fl_left > 0);
    st = stc && !fl;
    is = dec_valid_i && !st && !fl;
    obs_issue = issue_o; obs_stall = stall_o; obs_flush = flush_o;
    obs_fa = fwd_a_sel_o; obs_fb = fwd_b_sel_o;
    check("issue", {3'b0, obs_issue}, {3'b0, is});
    check("stall", {3'b0, obs_stall}, {3'b0, st});
    check("flush", {3'b0, obs_flush}, {3'b0, fl});
    check("fwd_a", {2'b0, obs_fa}, {2'b0, ea});
    check("fwd_b", {2'b0, obs_fb}, {2'b0, eb});
    if (is && dec_wr_en_i && dec_rd_addr_i != 4'd15) pend[dec_rd_addr_i]++;
    if (wb_en_i && wb_addr_i != 4'd15) pend[wb_addr_i]--;
    if (sq_en_i && sq_addr_i != 4'd15) pend[sq_addr_i]--;
    if (branch_taken_i) fl_left = FLUSH_CYCLES;
    else if (fl_left > 0) fl_left--;
    @(posedge clk_i);
    #1;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic do_reset(input string tag);
    #2 reset_ni = 0;
    #1;
    check({tag, "_flush"}, {3'b0, flush_o}, 4'd0);
    check({tag, "_stall"}, {3'b0, stall_o}, 4'd0);
    check({tag, "_issue"}, {3'b0, issue_o}, 4'd0);
    check({tag, "_fwd"}, {fwd_a_sel_o, fwd_b_sel_o}, 4'd0);
    model_clear();
    @(posedge clk_i);
    #3 reset_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] pick_addr();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
  endfunction

  task automatic rand_inputs();
    logic [3:0] r;
    dec_valid_i   = ($urandom_range(0, 9) < 8);
    dec_r1_addr_i = pick_addr();
    dec_r2_addr_i = pick_addr();
    dec_r1_used_i = $urandom_range(0, 1) == 1;
    dec_r2_used_i = $urandom_range(0, 1) == 1;
    dec_rd_addr_i = pick_addr();
    dec_wr_en_i   = ($urandom_range(0, 9) < 6);
    ex_valid_i    = $urandom_range(0, 1) == 1;
    ex_wr_en_i    = $urandom_range(0, 1) == 1;
    ex_is_load_i  = $urandom_range(0, 2) == 0;
    ex_rd_addr_i  = pick_addr();
    mem_valid_i   = $urandom_range(0, 1) == 1;
    mem_wr_en_i   = $urandom_range(0, 1) == 1;
    mem_rd_addr_i = pick_addr();
    r = pick_addr();
    wb_addr_i = r;
    wb_en_i   = ($urandom_range(0, 9) < 4) && (r == 4'd15 || pend[r] > 0);
    r = pick_addr();
    sq_addr_i = r;
    sq_en_i   = ($urandom_range(0, 9) == 0) &&
                (r == 4'd15 || pend[r] > ((wb_en_i && wb_addr_i == r) ? 1 : 0));
    branch_taken_i = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    clear_inputs();
    model_clear();
    reset_ni = 0;
    dec_valid_i = 1; dec_r1_used_i = 1; dec_wr_en_i = 1;
    ex_valid_i = 1; ex_wr_en_i = 1; wb_en_i = 1;
    #3;
    check("rst_issue", {3'b0, issue_o}, 4'd0);
    check("rst_stall", {3'b0, stall_o}, 4'd0);
    check("rst_flush", {3'b0, flush_o}, 4'd0);
    check("rst_fwd", {fwd_a_sel_o, fwd_b_sel_o}, 4'd0);
    @(posedge clk_i);
    #3 reset_ni = 1;
    @(posedge clk_i);
    #1;
    clear_inputs();

    // RAW on r3
    dec_valid_i = 1; dec_wr_en_i = 1; dec_rd_addr_i = 3;
    step();
    check("raw_issue_wr", {3'b0, obs_issue}, 4'd1);
    clear_inputs(); dec_valid_i = 1; dec_r1_used_i = 1; dec_r1_addr_i = 3;
    step();
`ifndef HAZARD_FWD_EN
    check("raw_stall", {3'b0, obs_stall}, 4'd1);
`endif
    step();
    wb_en_i = 1; wb_addr_i = 3;
    step();
    wb_en_i = 0;
    step();
    check("raw_release", {3'b0, obs_stall}, 4'd0);
    check("raw_release_issue", {3'b0, obs_issue}, 4'd1);

`ifdef HAZARD_FWD_EN
    clear_inputs(); dec_valid_i = 1; dec_r1_used_i = 1; dec_r1_addr_i = 3;
    ex_valid_i = 1; ex_wr_en_i = 1; ex_rd_addr_i = 3;
    step();
    check("fwd_ex_sel", {2'b0, obs_fa}, 4'd1);
    check("fwd_ex_stall", {3'b0, obs_stall}, 4'd0);
    ex_is_load_i = 1;
    step();
    check("load_use_stall", {3'b0, obs_stall}, 4'd1);
    ex_valid_i = 0; ex_is_load_i = 0; mem_valid_i = 1; mem_wr_en_i = 1; mem_rd_addr_i = 3;
    step();
    check("fwd_mem_sel", {2'b0, obs_fa}, 4'd2);
    check("fwd_mem_stall", {3'b0, obs_stall}, 4'd0);
`endif

    // Coincident issue, writeback and squash on r5
    clear_inputs(); dec_valid_i = 1; dec_wr_en_i = 1; dec_rd_addr_i = 5;
    step();
    step();
    wb_en_i = 1; wb_addr_i = 5; sq_en_i = 1; sq_addr_i = 5;
    step();
    check("sim_issue", {3'b0, obs_issue}, 4'd1);
    clear_inputs(); wb_en_i = 1; wb_addr_i = 5;
    step();
    clear_inputs(); dec_valid_i = 1; dec_r1_used_i = 1; dec_r1_addr_i = 5;
    step();
    check("sim_r5_free", {3'b0, obs_stall}, 4'd0);

    clear_inputs(); dec_valid_i = 1; dec_wr_en_i = 1; dec_rd_addr_i = 15;
    dec_r1_used_i = 1; dec_r1_addr_i = 15; dec_r2_used_i = 1; dec_r2_addr_i = 15;
    for (int i = 0; i < 5; i++) begin
      step();
      check("r15_nostall", {3'b0, obs_stall}, 4'd0);
    end

    // Saturation of r7
    clear_inputs(); dec_valid_i = 1; dec_wr_en_i = 1; dec_rd_addr_i = 7;
    for (int i = 0; i < CMAX; i++) begin
      step();
      check("sat_fill_issue", {3'b0, obs_issue}, 4'd1);
    end
    step();
    check("sat_stall", {3'b0, obs_stall}, 4'd1);
    check("sat_no_issue", {3'b0, obs_issue}, 4'd0);
    wb_en_i = 1; wb_addr_i = 7;
    step();
    check("sat_stall_wb", {3'b0, obs_stall}, 4'd1);
    wb_en_i = 0;
    step();
    check("sat_release", {3'b0, obs_issue}, 4'd1);

    // Branch flush and re-trigger
    clear_inputs(); dec_valid_i = 1; branch_taken_i = 1;
    step();
    branch_taken_i = 0;
    step();
    check("br_flush1", {3'b0, obs_flush}, 4'd1);
    check("br_noissue", {3'b0, obs_issue}, 4'd0);
    step();
    check("br_flush2", {3'b0, obs_flush}, 4'd1);
    step();
    check("br_done", {3'b0, obs_flush}, 4'd0);
    branch_taken_i = 1;
    step();
    branch_taken_i = 1;
    step();
    check("br2_flush1", {3'b0, obs_flush}, 4'd1);
    branch_taken_i = 0;
    step();
    step();
    check("br2_extend", {3'b0, obs_flush}, 4'd1);
    step();
    check("br2_done", {3'b0, obs_flush}, 4'd0);

    // Reset in the middle of a flush, with r7 still pending
    branch_taken_i = 1;
    step();
    branch_taken_i = 0;
    do_reset("rst_mid");
    clear_inputs(); dec_valid_i = 1; dec_r1_used_i = 1; dec_r1_addr_i = 7;
    step();
    check("rst_cnt_clear", {3'b0, obs_stall}, 4'd0);
    check("rst_idle", {3'b0, obs_flush}, 4'd0);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
